bg_scroll_controller: RTL and testbench
=======================================

# bg_scroll_controller

Sequencer for the background tile engine. Once per frame it advances the 4-bit sub-tile scroll offset consumed by the tile renderer. When the offset wraps past one tile width, it uses vertical blanking to shift every scrolling tile-map row left by one column. Each row's vacated rightmost column is refilled from an external column generator. It owns the tile-map RAM port during its active window; the renderer reads the RAM only while `busy` is low.

## Interface
- TILE_COLS, 40, tile-map columns per row
- TILE_ROWS, 30, tile-map rows
- SCROLL_ROW_FIRST, 7, first row that scrolls; rows above are static (HUD/sky)
- clk  in  1  system/pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- run  in  1  scrolling enabled; sampled on frame_start
- speed  in  4  pixels advanced per frame, 0..15
- x_offset  out  4  sub-tile horizontal offset to renderer
- busy  out  1  controller owns tile-map RAM
- overrun  out  1  sticky: frame_start arrived while busy
- mem_addr  out  16  tile-map RAM address, row*TILE_COLS+col
- mem_we  out  1  write strobe
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid one cycle after address
- gen_req  out  1  request new tile for column TILE_COLS-1
- gen_row  out  5  row index for request
- gen_ack  in  1  generator accepts; gen_tile valid this cycle
- gen_tile  in  16  new tile word

## Operation
- Reset: x_offset=0, busy=0, overrun=0, mem_we=0, mem_addr=0, mem_wdata=0, gen_req=0, gen_row=0, FSM=IDLE. Reset mid-shift aborts immediately; the partially shifted map is left as-is.
- IDLE, on frame_start with run=1: sum = x_offset + speed, 5-bit.
  - sum<16: x_offset<=sum[3:0] next cycle; no RAM activity.
  - sum>=16: latch pending_offset=sum-16; go to RD with row=SCROLL_ROW_FIRST, col=0.
- frame_start with run=0: no change.
- RD: mem_addr=rowbase+col+1, mem_we=0 → WR.
- WR: mem_addr=rowbase+col, mem_wdata=mem_rdata, mem_we=1.
  - col<TILE_COLS-2: col++ → RD.
  - Otherwise → GEN.
- GEN: gen_req=1, gen_row=row. Hold until gen_ack=1; latch gen_tile on the ack cycle → WRNEW.
- WRNEW: write gen_tile at rowbase+TILE_COLS-1.
  - row<TILE_ROWS-1: row++, rowbase+=TILE_COLS, col=0 → RD.
  - Otherwise → DONE.
- DONE: x_offset<=pending_offset, busy<=0 → IDLE.
- rowbase is a running register (add TILE_COLS per row); no multiplier.
- frame_start while not IDLE: ignored, overrun<=1; cleared only by reset.
- speed changes mid-shift have no effect until the next frame_start.
- At most one column shift per frame, since speed<=15.

## Timing
- Non-shift frame: x_offset valid on the cycle after frame_start; busy stays 0.
- Shift frame: busy=1 from the cycle after frame_start through the DONE cycle. It is registered low in the same edge that loads x_offset.
- Copy step: 2 cycles per entry (RD, WR). 39 entries per row.
- Generator step: 1 cycle per row if gen_ack is high on the first GEN cycle, plus 1 cycle per extra wait cycle.
- Row cost is 80 cycles with zero generator wait. With defaults (23 rows), the shift lasts 1840 cycles plus DONE, well within 45 blanking lines at 800 clocks.
- gen_req is a registered output, high only in GEN. It deasserts the cycle after the ack.
- mem_* are registered outputs. mem_we is never high outside the WR and WRNEW states.

## Structure
- Shared package: TILE_COLS, TILE_ROWS, TILE_WIDTH=16, the tile-word field layout (col[2:0], row[5:3], xflip[6], yflip[7], enable[8]), and the FSM state encoding.
- Single module. No sub-module is needed; the address counter is inline.

## Test plan
- Reset then speed=5, run=1, three frame_starts: x_offset 5, 10, 15; no mem_we pulses.
- x_offset=15, speed=3, map preloaded with word=addr: x_offset goes 2 at the DONE edge. Required map values:
  - Row 7 col 0 = 281; row 29 col 38 = 1199.
  - Col 39 of each row = gen_tile.
  - Rows 0..6 unchanged.
- Generator delays gen_ack 4 cycles on row 10: gen_req held 4+ cycles with gen_row=10; total busy length increases by exactly 4.
- frame_start during shift: overrun=1; shift completes normally; the extra frame does not advance x_offset.
- reset_n low at mid-row 12: all outputs reset on the reset edge. After release, a non-shift frame_start behaves as in the first scenario.
- run=0 with speed=9: x_offset frozen across frames; busy stays 0.

Source files
------------

// File: rtl/bg_scroll_controller_pkg.sv
`default_nettype none
//============================================================================
// Module      : bg_scroll_controller_pkg
// Description : Shared constants for the background scroll controller:
//               tile-map geometry, tile-word field layout and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
//============================================================================
package bg_scroll_controller_pkg;

    localparam int TILE_COLS        = 40;
    localparam int TILE_ROWS        = 30;
    localparam int TILE_WIDTH       = 16;
    localparam int SCROLL_ROW_FIRST = 7;

    // Layout of one tile-map word as the renderer interprets it.
    typedef struct packed {
        logic [6:0] reserved;
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic [2:0] row;
        logic [2:0] col;
    } tile_word_t;

    localparam int         c_STATE_W   = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RD     = 3'd1;
    localparam logic [2:0] c_ST_WR     = 3'd2;
    localparam logic [2:0] c_ST_GEN    = 3'd3;
    localparam logic [2:0] c_ST_WRNEW  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/bg_scroll_controller.sv
`default_nettype none
//============================================================================
// Module      : bg_scroll_controller
// Description : Per-frame background scroll sequencer. Advances the 4-bit
//               sub-tile offset each frame; when it wraps past a tile it
//               shifts every scrolling tile-map row left one column during
//               vertical blanking and refills the last column from an
//               external column generator.
// Ports       : clk, reset_n      - clock, async active-low reset
//               frame_start, run, speed - per-frame control
//               x_offset          - sub-tile offset to the renderer
//               busy, overrun     - RAM ownership / sticky late-frame flag
//               mem_*             - tile-map RAM port (registered)
//               gen_*             - column generator handshake
// Revision    : 1.0 - initial release
//============================================================================
module bg_scroll_controller #(
    parameter int TILE_COLS        = bg_scroll_controller_pkg::TILE_COLS,
    parameter int TILE_ROWS        = bg_scroll_controller_pkg::TILE_ROWS,
    parameter int SCROLL_ROW_FIRST = bg_scroll_controller_pkg::SCROLL_ROW_FIRST
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        run,
    input  logic [3:0]  speed,
    output logic [3:0]  x_offset,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [bg_scroll_controller_pkg::TILE_WIDTH-1:0] mem_wdata,
    input  logic [bg_scroll_controller_pkg::TILE_WIDTH-1:0] mem_rdata,
    output logic        gen_req,
    output logic [4:0]  gen_row,
    input  logic        gen_ack,
    input  logic [bg_scroll_controller_pkg::TILE_WIDTH-1:0] gen_tile
);
    import bg_scroll_controller_pkg::*;

    localparam logic [5:0]  c_COL_LAST_COPY = 6'(TILE_COLS - 2);
    localparam logic [4:0]  c_ROW_LAST      = 5'(TILE_ROWS - 1);
    localparam logic [4:0]  c_ROW_FIRST     = 5'(SCROLL_ROW_FIRST);
    // Elaboration-time constant; per-row bases are accumulated at run time.
    localparam logic [15:0] c_ROWBASE_FIRST = 16'(SCROLL_ROW_FIRST * TILE_COLS);
    localparam logic [15:0] c_COLS          = 16'(TILE_COLS);
    localparam logic [15:0] c_LAST_COL      = 16'(TILE_COLS - 1);

    logic [c_STATE_W-1:0] r_state, w_state_nxt;
    logic [3:0]  r_x_offset, w_x_offset_nxt;
    logic [3:0]  r_pending,  w_pending_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_overrun,  w_overrun_nxt;
    logic [15:0] r_mem_addr, w_mem_addr_nxt;
    logic        r_mem_we,   w_mem_we_nxt;
    logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_gen_req,  w_gen_req_nxt;
    logic [15:0] r_gen_tile, w_gen_tile_nxt;
    logic [4:0]  r_row,      w_row_nxt;
    logic [5:0]  r_col,      w_col_nxt;
    logic [15:0] r_rowbase,  w_rowbase_nxt;

    logic [4:0]  w_sum;
    logic [15:0] w_col_addr;

    // 5-bit sum: bit 4 set means the offset wrapped past one tile.
    assign w_sum      = {1'b0, r_x_offset} + {1'b0, speed};
    assign w_col_addr = r_rowbase + 16'(r_col);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_x_offset  <= 4'd0;
            r_pending   <= 4'd0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 16'd0;
            r_gen_req   <= 1'b0;
            r_gen_tile  <= 16'd0;
            r_row       <= 5'd0;
            r_col       <= 6'd0;
            r_rowbase   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_x_offset  <= w_x_offset_nxt;
            r_pending   <= w_pending_nxt;
            r_busy      <= w_busy_nxt;
            r_overrun   <= w_overrun_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_gen_req   <= w_gen_req_nxt;
            r_gen_tile  <= w_gen_tile_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_rowbase   <= w_rowbase_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (frame_start && run && w_sum[4]) w_state_nxt = c_ST_RD;
            c_ST_RD:    w_state_nxt = c_ST_WR;
            c_ST_WR:    w_state_nxt = (r_col < c_COL_LAST_COPY) ? c_ST_RD : c_ST_GEN;
            c_ST_GEN:   if (gen_ack) w_state_nxt = c_ST_WRNEW;
            c_ST_WRNEW: w_state_nxt = (r_row < c_ROW_LAST) ? c_ST_RD : c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_x_offset_nxt  = r_x_offset;
        w_pending_nxt   = r_pending;
        w_busy_nxt      = r_busy;
        w_overrun_nxt   = r_overrun;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_gen_req_nxt   = r_gen_req;
        w_gen_tile_nxt  = r_gen_tile;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_rowbase_nxt   = r_rowbase;

        // A frame arriving mid-shift is dropped but remembered.
        if (frame_start && (r_state != c_ST_IDLE)) w_overrun_nxt = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (frame_start && run) begin
                    if (!w_sum[4]) begin
                        w_x_offset_nxt = w_sum[3:0];
                    end else begin
                        // Offset is held until the shifted map is complete.
                        w_pending_nxt = w_sum[3:0];
                        w_busy_nxt    = 1'b1;
                        w_row_nxt     = c_ROW_FIRST;
                        w_col_nxt     = 6'd0;
                        w_rowbase_nxt = c_ROWBASE_FIRST;
                    end
                end
            end
            c_ST_RD: begin
                w_mem_addr_nxt = w_col_addr + 16'd1;
            end
            c_ST_WR: begin
                w_mem_addr_nxt  = w_col_addr;
                w_mem_wdata_nxt = mem_rdata;
                w_mem_we_nxt    = 1'b1;
                if (r_col < c_COL_LAST_COPY) w_col_nxt = r_col + 6'd1;
                else                         w_gen_req_nxt = 1'b1;
            end
            c_ST_GEN: begin
                if (gen_ack) begin
                    w_gen_tile_nxt = gen_tile;
                    w_gen_req_nxt  = 1'b0;
                end
            end
            c_ST_WRNEW: begin
                w_mem_addr_nxt  = r_rowbase + c_LAST_COL;
                w_mem_wdata_nxt = r_gen_tile;
                w_mem_we_nxt    = 1'b1;
                if (r_row < c_ROW_LAST) begin
                    w_row_nxt     = r_row + 5'd1;
                    w_rowbase_nxt = r_rowbase + c_COLS;
                    w_col_nxt     = 6'd0;
                end
            end
            c_ST_DONE: begin
                w_x_offset_nxt = r_pending;
                w_busy_nxt     = 1'b0;
            end
            default: ;
        endcase
    end

    assign x_offset  = r_x_offset;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign gen_req   = r_gen_req;
    assign gen_row   = r_row;

endmodule
`default_nettype wire

// File: tb/tb_bg_scroll_controller.sv
`default_nettype none
//============================================================================
// Module      : tb_bg_scroll_controller
// Description : Directed self-checking bench for bg_scroll_controller with
//               a tile-map RAM model and a column generator model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_bg_scroll_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [3:0]  x_offset;
    logic        busy;
    logic        overrun;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        gen_req;
    logic [4:0]  gen_row;
    logic        gen_ack = 1'b0;
    logic [15:0] gen_tile;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bg_scroll_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .run         (run),
        .speed       (speed),
        .x_offset    (x_offset),
        .busy        (busy),
        .overrun     (overrun),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .gen_req     (gen_req),
        .gen_row     (gen_row),
        .gen_ack     (gen_ack),
        .gen_tile    (gen_tile)
    );

    // Tile-map RAM: 30 x 40 words
    logic [15:0] ram [0:1199];
    int          we_count = 0;

    assign mem_rdata = (mem_addr < 16'd1200) ? ram[mem_addr] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_we) begin
            we_count <= we_count + 1;
            if (mem_addr < 16'd1200) ram[mem_addr] <= mem_wdata;
        end
    end

    // Column generator: tile word tags the row; optional 4-cycle stall on row 10
    bit delay_en = 1'b0;
    int wait_cnt = 0;
    int req_run  = 0;
    int req_max  = 0;

    assign gen_tile = 16'hA000 | {11'd0, gen_row};

    always @(negedge clk) begin
        if (gen_req && delay_en && gen_row == 5'd10 && wait_cnt < 4) begin
            gen_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end else begin
            gen_ack = gen_req;
            if (!gen_req) wait_cnt = 0;
        end
        if (gen_req && gen_row == 5'd10) begin
            req_run = req_run + 1;
            if (req_run > req_max) req_max = req_run;
        end else begin
            req_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_x_offset"},  32'(x_offset),  0);
        check_eq({tag, "_busy"},      32'(busy),      0);
        check_eq({tag, "_overrun"},   32'(overrun),   0);
        check_eq({tag, "_mem_we"},    32'(mem_we),    0);
        check_eq({tag, "_mem_addr"},  32'(mem_addr),  0);
        check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check_eq({tag, "_gen_req"},   32'(gen_req),   0);
        check_eq({tag, "_gen_row"},   32'(gen_row),   0);
    endtask

    // One-cycle frame_start pulse; returns on the negedge after the sampling edge.
    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Waits for busy to drop, counting busy cycles; optionally injects a
    // late frame_start 100 cycles in. Flags any x_offset movement while busy.
    task automatic wait_shift(input bit inject, input logic [3:0] x_hold,
                              output int cycles, output bit moved);
        cycles = 0;
        moved  = 1'b0;
        while (busy && cycles < 4000) begin
            if (x_offset != x_hold) moved = 1'b1;
            frame_start = inject && (cycles == 100);
            cycles++;
            @(negedge clk);
        end
        frame_start = 1'b0;
    endtask

    initial begin
        int cyc;
        bit moved;
        int we0;
        int bad;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Non-shift frames: speed 5
        speed = 4'd5;
        run   = 1'b1;
        we0   = we_count;
        for (int i = 1; i <= 3; i++) begin
            pulse_frame();
            check_eq("nonshift_x_offset", 32'(x_offset), 32'(5 * i));
            check_eq("nonshift_busy",     32'(busy),     0);
        end
        check_eq("nonshift_no_we", 32'(we_count - we0), 0);

        // Shift frame: 15 + 3 = 18 -> offset 2, map preloaded word = address
        for (int a = 0; a < 1200; a++) ram[a] <= 16'(a);
        @(negedge clk);
        speed = 4'd3;
        we0   = we_count;
        pulse_frame();
        check_eq("shift_busy_start", 32'(busy),     1);
        check_eq("shift_x_held",     32'(x_offset), 15);
        wait_shift(1'b0, 4'd15, cyc, moved);
        check_eq("shift_busy_end",   32'(busy),     0);
        check_eq("shift_busy_len",   32'(cyc),      1841);
        check_eq("shift_x_stable",   32'(moved),    0);
        check_eq("shift_x_done",     32'(x_offset), 2);
        check_eq("shift_we_count",   32'(we_count - we0), 920);
        check_eq("shift_overrun",    32'(overrun),  0);
        check_eq("row7_col0",        32'(ram[280]),  281);
        check_eq("row29_col38",      32'(ram[1198]), 1199);
        for (int r = 7; r < 30; r++)
            check_eq("col39_gen_tile", 32'(ram[r * 40 + 39]), 32'(16'hA000 + r));
        bad = 0;
        for (int a = 0; a < 280; a++) if (ram[a] != 16'(a)) bad++;
        check_eq("static_rows_unchanged", 32'(bad), 0);
        bad = 0;
        for (int r = 7; r < 30; r++)
            for (int c = 0; c < 39; c++)
                if (ram[r * 40 + c] != 16'(r * 40 + c + 1)) bad++;
        check_eq("shifted_body", 32'(bad), 0);

        // Shift with generator stall on row 10 and a late frame_start: 2+15=17 -> 1
        delay_en = 1'b1;
        speed    = 4'd15;
        pulse_frame();
        wait_shift(1'b1, 4'd2, cyc, moved);
        delay_en = 1'b0;
        check_eq("stall_busy_len",    32'(cyc),      1845);
        check_eq("stall_req_hold",    32'(req_max),  5);
        check_eq("stall_overrun",     32'(overrun),  1);
        check_eq("stall_x_stable",    32'(moved),    0);
        check_eq("stall_x_done",      32'(x_offset), 1);

        // Reset mid-row 12: 1 + 15 = 16 starts a shift
        pulse_frame();
        n = 0;
        while (gen_row != 5'd12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_row12", 32'(gen_row), 12);
        repeat (41) @(negedge clk);
        check_eq("midrow_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        speed   = 4'd5;
        pulse_frame();
        check_eq("post_reset_x_offset", 32'(x_offset), 5);
        check_eq("post_reset_busy",     32'(busy),     0);

        // run = 0 freezes the offset
        run   = 1'b0;
        speed = 4'd9;
        we0   = we_count;
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            check_eq("frozen_x_offset", 32'(x_offset), 5);
            check_eq("frozen_busy",     32'(busy),     0);
        end
        check_eq("frozen_no_we", 32'(we_count - we0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
